// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle MIPS control FSM (IF/DCD/EXE/MEM/WB) with a
//               memory wait counter for IF and MEM.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_cycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic [1:0] extOp,
  output logic [2:0] aluOp,
  output logic       aluSrcB,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic [1:0] npcOp,
  output logic [2:0] state
);

  localparam int              c_cw   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(MEM_LAT - 1);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addiu = 6'b001001;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_fn_addu  = 6'b100001;
  localparam logic [5:0] c_fn_subu  = 6'b100011;
  localparam logic [5:0] c_fn_slt   = 6'b101010;
  localparam logic [5:0] c_fn_jr    = 6'b001000;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [c_cw-1:0] r_cnt;

  logic w_last, w_rtype, w_r_alu, w_jr, w_i_alu, w_lw, w_sw, w_beq, w_supported;

  assign w_last  = (r_cnt == c_last);
  assign w_rtype = (op == c_op_rtype);
  assign w_r_alu = w_rtype && (funct == c_fn_addu || funct == c_fn_subu || funct == c_fn_slt);
  assign w_jr    = w_rtype && (funct == c_fn_jr);
  assign w_i_alu = (op == c_op_ori) || (op == c_op_addiu) || (op == c_op_lui);
  assign w_lw    = (op == c_op_lw);
  assign w_sw    = (op == c_op_sw);
  assign w_beq   = (op == c_op_beq);
  assign w_supported = w_r_alu || w_i_alu || w_lw || w_sw || w_beq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_IF || r_state == S_MEM)
        r_cnt <= r_cnt + c_cw'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    extOp    = 2'b00;
    aluOp    = 3'b000;
    aluSrcB  = 1'b0;
    regDst   = 2'b00;
    memToReg = 2'b00;
    npcOp    = 2'b00;
    state    = r_state;
    case (r_state)
      S_IF: begin
        if (w_last) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          w_next  = S_DCD;
        end
      end
      S_DCD: begin
        w_next = S_IF;
        if (op == c_op_j || op == c_op_jal) begin
          pcWrite = 1'b1;
          npcOp   = 2'b10;
          if (op == c_op_jal) begin
            regWrite = 1'b1;
            regDst   = 2'b10;
            memToReg = 2'b10;
          end
        end else if (w_jr) begin
          pcWrite = 1'b1;
          npcOp   = 2'b11;
        end else if (w_supported) begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        w_next = S_IF;
        if (w_r_alu) begin
          aluOp  = (funct == c_fn_subu) ? 3'b001 : (funct == c_fn_slt) ? 3'b011 : 3'b000;
          w_next = S_WB;
        end else if (op == c_op_ori) begin
          aluOp   = 3'b010;
          aluSrcB = 1'b1;
          w_next  = S_WB;
        end else if (op == c_op_addiu) begin
          aluSrcB = 1'b1;
          extOp   = 2'b01;
          w_next  = S_WB;
        end else if (op == c_op_lui) begin
          aluOp   = 3'b100;
          aluSrcB = 1'b1;
          extOp   = 2'b10;
          w_next  = S_WB;
        end else if (w_lw || w_sw) begin
          aluSrcB = 1'b1;
          extOp   = 2'b01;
          w_next  = S_MEM;
        end else if (w_beq) begin
          aluOp   = 3'b001;
          extOp   = 2'b01;
          npcOp   = 2'b01;
          pcWrite = zero;
        end
      end
      S_MEM: begin
        if (w_last) begin
          memWrite = w_sw;
          w_next   = w_lw ? S_WB : S_IF;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = w_rtype ? 2'b01 : 2'b00;
        memToReg = w_lw ? 2'b01 : 2'b00;
        w_next   = S_IF;
      end
      default: w_next = S_IF;
    endcase
    // Reset silences every output immediately, not just after the edge.
    if (rst) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
      extOp    = 2'b00;
      aluOp    = 3'b000;
      aluSrcB  = 1'b0;
      regDst   = 2'b00;
      memToReg = 2'b00;
      npcOp    = 2'b00;
      state    = 3'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Self-checking bench for multi_cycle_ctrl at MEM_LAT=1 and 3.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rgw;
    logic       mw;
    logic [1:0] ext;
    logic [2:0] alu;
    logic       srcb;
    logic [1:0] dst;
    logic [1:0] m2r;
    logic [1:0] npc;
    logic [2:0] st;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, rst3 = 1'b1;
  logic [5:0] op1 = '0, funct1 = '0, op3 = '0, funct3 = '0;
  logic       zero1 = 1'b0, zero3 = 1'b0;
  vec_t       got1, got3;

  multi_cycle_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .op(op1), .funct(funct1), .zero(zero1),
    .pcWrite(got1.pcw), .irWrite(got1.irw), .regWrite(got1.rgw), .memWrite(got1.mw),
    .extOp(got1.ext), .aluOp(got1.alu), .aluSrcB(got1.srcb), .regDst(got1.dst),
    .memToReg(got1.m2r), .npcOp(got1.npc), .state(got1.st)
  );

  multi_cycle_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .op(op3), .funct(funct3), .zero(zero3),
    .pcWrite(got3.pcw), .irWrite(got3.irw), .regWrite(got3.rgw), .memWrite(got3.mw),
    .extOp(got3.ext), .aluOp(got3.alu), .aluSrcB(got3.srcb), .regDst(got3.dst),
    .memToReg(got3.m2r), .npcOp(got3.npc), .state(got3.st)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t q1[$];
  vec_t q3[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected per-cycle trace of one instruction, from instruction class and latency.
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int lat, output vec_t tr[$]);
    vec_t v;
    bit is_r, r_alu, jr, ialu, lw, sw, beq, jmp, jal;
    tr.delete();
    is_r  = (o == 6'b000000);
    r_alu = is_r && (f == 6'b100001 || f == 6'b100011 || f == 6'b101010);
    jr    = is_r && (f == 6'b001000);
    ialu  = (o == 6'b001101 || o == 6'b001001 || o == 6'b001111);
    lw    = (o == 6'b100011);
    sw    = (o == 6'b101011);
    beq   = (o == 6'b000100);
    jmp   = (o == 6'b000010);
    jal   = (o == 6'b000011);
    for (int i = 0; i < lat; i++) begin
      v = '0;
      if (i == lat - 1) begin v.pcw = 1; v.irw = 1; end
      tr.push_back(v);
    end
    v = '0; v.st = 3'd1;
    if (jmp || jal) begin v.pcw = 1; v.npc = 2'b10; end
    if (jal) begin v.rgw = 1; v.dst = 2'b10; v.m2r = 2'b10; end
    if (jr) begin v.pcw = 1; v.npc = 2'b11; end
    tr.push_back(v);
    if (!(r_alu || ialu || lw || sw || beq)) return;
    v = '0; v.st = 3'd2;
    if (r_alu) v.alu = (f == 6'b100011) ? 3'd1 : (f == 6'b101010) ? 3'd3 : 3'd0;
    if (o == 6'b001101) begin v.alu = 3'd2; v.srcb = 1; v.ext = 2'b00; end
    if (o == 6'b001001 || lw || sw) begin v.alu = 3'd0; v.srcb = 1; v.ext = 2'b01; end
    if (o == 6'b001111) begin v.alu = 3'd4; v.srcb = 1; v.ext = 2'b10; end
    if (beq) begin v.alu = 3'd1; v.ext = 2'b01; v.npc = 2'b01; v.pcw = z; end
    tr.push_back(v);
    if (beq) return;
    if (lw || sw) begin
      for (int i = 0; i < lat; i++) begin
        v = '0; v.st = 3'd3;
        if (sw && i == lat - 1) v.mw = 1;
        tr.push_back(v);
      end
      if (sw) return;
    end
    v = '0; v.st = 3'd4; v.rgw = 1;
    v.dst = is_r ? 2'b01 : 2'b00;
    v.m2r = lw ? 2'b01 : 2'b00;
    tr.push_back(v);
  endfunction

  task automatic drive(input int d, input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input vec_t e);
    @(posedge clk);
    #1;
    if (d == 1) begin rst1 = r; op1 = o; funct1 = f; zero1 = z; q1.push_back(e); end
    else        begin rst3 = r; op3 = o; funct3 = f; zero3 = z; q3.push_back(e); end
  endtask

  // cut >= 0 truncates the instruction after that many cycles and asserts rst.
  task automatic run(input int d, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int cut);
    vec_t tr[$];
    int   n;
    build(o, f, z, (d == 1) ? 1 : 3, tr);
    n = (cut >= 0) ? cut : tr.size();
    for (int i = 0; i < n; i++) drive(d, 1'b0, o, f, z, tr[i]);
    if (cut >= 0) drive(d, 1'b1, o, f, z, '0);
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0) chk("lat1 outputs", 32'(got1), 32'(q1.pop_front()));
    if (q3.size() > 0) chk("lat3 outputs", 32'(got3), 32'(q3.pop_front()));
  end

  initial begin
    vec_t tr[$];
    int   ones;

    // Model pins against hand-derived numbers
    build(6'b100011, 6'd0, 1'b0, 1, tr);
    chk("model lw length", tr.size(), 5);
    for (int i = 0; i < 5; i++) chk("model lw state seq", tr[i].st, i);
    chk("model lw exe ext/srcb", {tr[2].ext, tr[2].srcb}, 3'b011);
    chk("model lw wb m2r/rgw", {tr[4].m2r, tr[4].rgw}, 3'b011);
    build(6'b101011, 6'd0, 1'b0, 3, tr);
    chk("model sw lat3 length", tr.size(), 8);
    ones = 0;
    foreach (tr[i]) ones += tr[i].mw;
    chk("model sw single write", ones, 1);
    chk("model sw write last", tr[7].mw, 1);
    build(6'b000100, 6'd0, 1'b1, 1, tr);
    chk("model beq length", tr.size(), 3);
    chk("model beq taken pcw/npc", {tr[2].pcw, tr[2].npc}, 3'b101);
    build(6'b000010, 6'd0, 1'b0, 1, tr);
    chk("model j length", tr.size(), 2);
    build(6'b001111, 6'd0, 1'b0, 1, tr);
    chk("model lui ext/alu", {tr[2].ext, tr[2].alu}, 5'b10100);

    // Two reset cycles on both instances
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst1 = 1; rst3 = 1; op1 = 6'b100011; op3 = 6'b111111;
      q1.push_back('0); q3.push_back('0);
    end

    run(1, 6'b100011, 6'd0,      1'b0, -1);  // lw
    run(1, 6'b000000, 6'b100001, 1'b0, -1);  // addu
    run(1, 6'b000000, 6'b100011, 1'b0, -1);  // subu
    run(1, 6'b000000, 6'b101010, 1'b0, -1);  // slt
    run(1, 6'b001101, 6'd0,      1'b0, -1);  // ori
    run(1, 6'b001001, 6'd0,      1'b0, -1);  // addiu
    run(1, 6'b001111, 6'd0,      1'b0, -1);  // lui
    run(1, 6'b101011, 6'd0,      1'b0, -1);  // sw
    run(1, 6'b000100, 6'd0,      1'b1, -1);  // beq taken
    run(1, 6'b000100, 6'd0,      1'b0, -1);  // beq not taken
    run(1, 6'b000010, 6'd0,      1'b0, -1);  // j
    run(1, 6'b000011, 6'd0,      1'b0, -1);  // jal
    run(1, 6'b000000, 6'b001000, 1'b0, -1);  // jr
    run(1, 6'b111111, 6'd0,      1'b0, -1);  // illegal op
    run(1, 6'b000000, 6'b000000, 1'b0, -1);  // unsupported funct
    run(1, 6'b100011, 6'd0,      1'b0, 3);   // lw aborted in MEM
    run(1, 6'b001101, 6'd0,      1'b0, -1);

    run(3, 6'b101011, 6'd0,      1'b0, -1);  // sw, 8 cycles
    run(3, 6'b100011, 6'd0,      1'b0, -1);  // lw
    run(3, 6'b000010, 6'd0,      1'b0, -1);  // j
    run(3, 6'b101011, 6'd0,      1'b0, 7);   // sw aborted on final MEM cycle
    run(3, 6'b101011, 6'd0,      1'b0, 1);   // aborted mid-IF
    run(3, 6'b000000, 6'b100001, 1'b0, -1);  // addu
    run(3, 6'b000100, 6'd0,      1'b1, -1);  // beq taken

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
